char_buf_16x16_writer: RTL
==========================

# char_buf_16x16_writer

Writable 16x16 character buffer for the text overlay. It is the write-side counterpart of the fixed start-screen text ROMs: it accepts a stream of character codes and control codes over a valid/ready handshake and stores them at an auto-advancing cursor. The drawing pipeline reads it through the same `char_xy` to `char_code` lookup as the ROMs, so it can replace a ROM for runtime text such as scores and status lines.

## Interface
- `BLANK_CODE`, default `vga_pkg::Spc`: 7-bit code written by clear and backspace, and returned on reads during clear.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `wr_valid`  in  1  a write or command is offered.
- `wr_ready`  out  1  the block can accept; a transfer happens on an edge where `wr_valid && wr_ready`.
- `wr_data`  in  8  payload:
  - bit7=0: printable code `wr_data[6:0]`.
  - `8'h80`: newline. `8'h81`: clear. `8'h82`: backspace.
  - `8'h83`–`8'hff`: reserved; consumed and ignored.
- `cursor_xy`  out  8  current write position, `{row[3:0], col[3:0]}`.
- `busy`  out  1  high while in CLEAR state.
- `char_xy`  in  8  read address, `{row, col}`.
- `char_code`  out  7  registered read data.

## Operation
- Storage: 256 x 7 register array, addressed by `{row, col}`. The array itself is not reset.
- FSM has two states: IDLE and CLEAR.
  - `wr_ready = (state == IDLE)`, `busy = (state == CLEAR)`.
  - CLEAR writes `BLANK_CODE` to `mem[clr_addr]` and increments an 8-bit `clr_addr` every cycle.
  - When `clr_addr == 8'hff` has been written, the FSM goes to IDLE, so CLEAR lasts exactly 256 cycles.
- Reset puts the FSM in CLEAR with `clr_addr = 0`, `cursor_xy = 0` and `char_code = BLANK_CODE`. `wr_ready = 0` and `busy = 1` during reset.
- Accepted printable code: `mem[cursor] <= code`, then `cursor <= cursor + 1`. The cursor is 8-bit and wraps `8'hff` to `8'h00`, so column overflow rolls to the next row.
- Newline: `cursor <= {row + 1, 4'h0}`, with row 15 wrapping to row 0. Memory is unchanged.
- Backspace:
  - If `cursor != 0`: `cursor <= cursor - 1` and `mem[cursor - 1] <= BLANK_CODE`.
  - At `cursor == 0`: no-op, no wrap.
- Clear: `cursor <= 0`, `clr_addr <= 0`, enter CLEAR.
- Read port: `char_code <= (state == CLEAR) ? BLANK_CODE : mem[char_xy]`. Reads are independent of the handshake.
- Read during write to the same address on the same edge returns the old contents.
- Because only IDLE accepts, there is never a simultaneous command and clear.

## Timing
- Write latency: a transfer on edge N updates memory and `cursor_xy` at edge N. A read that samples that address at edge N+1 presents the new code after N+1.
- Read latency is 1 cycle from `char_xy` to `char_code`.
- Throughput is one command per cycle in IDLE; `wr_ready` stays high through back-to-back transfers.
- Clear command accepted at edge N:
  - `wr_ready` is low from N through N+256 (256 cycles, 256 blanking writes).
  - `wr_ready` is high again after edge N+256.
- After `rst_n` deasserts, `wr_ready` rises 256 edges later.
- `rst_n` asserted at any time, including mid-CLEAR or mid-stream, immediately forces the reset values and restarts a full 256-cycle CLEAR from address 0.
- `wr_data` is ignored whenever `wr_ready = 0`. The source must hold `wr_valid` and `wr_data` until the transfer occurs.

## Test plan
- **Reset/clear:**
  - Stimulus: release `rst_n`, sweep `char_xy` 0..255.
  - Required: `busy = 1` and `wr_ready = 0` for exactly 256 cycles, then `wr_ready = 1`.
  - Required: every read returns `BLANK_CODE`, and `cursor_xy = 8'h00`.
- **Printable writes:**
  - Stimulus: send `7'h47`, `7'h52` back-to-back.
  - Required: `mem[8'h00] = 7'h47`, `mem[8'h01] = 7'h52`, `cursor_xy = 8'h02`, and `wr_ready` never drops.
  - Required: reading `char_xy = 8'h01` returns `7'h52` one cycle later.
- **Wrap:**
  - Stimulus: 256 printable writes, then a 257th write `7'h33`.
  - Required: `cursor_xy` returns to `8'h00` after the 256th write.
  - Required: the 257th write overwrites `mem[8'h00]` with `7'h33`, and `cursor_xy = 8'h01`.
- **Newline:**
  - From `cursor_xy = 8'h35`: becomes `8'h40`.
  - From `8'hf3`: becomes `8'h00`.
  - Memory is unchanged in both cases.
- **Backspace:**
  - At `8'h00`: no change to cursor or memory.
  - At `8'h12` (with `mem[8'h11] = 7'h41`): cursor becomes `8'h11` and `mem[8'h11] = BLANK_CODE`.
  - Reserved `8'h90` is accepted, with no cursor or memory change.
- **Clear and reset mid-operation:**
  - Stimulus: send `8'h81`.
  - Required: `wr_ready` stays low 256 cycles, all cells read `BLANK_CODE`, `cursor_xy = 0`.
  - Stimulus: assert `rst_n` low at cycle 100 of a clear, then release.
  - Required: a full 256-cycle clear restarts from address 0.

Source files
------------

// File: rtl/char_buf_16x16_writer.sv
// char_buf_16x16_writer
// Writable 16x16 character buffer for the text overlay. Character and control
// codes arrive over a valid/ready handshake and are stored at an auto-advancing
// cursor. The drawing pipeline reads cells through char_xy -> char_code.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset; restarts a full clear
//   wr_valid   write/command offered
//   wr_ready   high in IDLE; a transfer happens on wr_valid && wr_ready
//   wr_data    bit7=0: printable code [6:0]; 80 newline, 81 clear,
//              82 backspace, 83..ff ignored
//   cursor_xy  current write position {row, col}
//   busy       high while the buffer is being blanked
//   char_xy    read address {row, col}
//   char_code  registered read data (BLANK_CODE while blanking)
module char_buf_16x16_writer #(
  parameter logic [6:0] BLANK_CODE = 7'h20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_data,
  output logic [7:0] cursor_xy,
  output logic       busy,
  input  logic [7:0] char_xy,
  output logic [6:0] char_code
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic [7:0] CMD_NEWLINE   = 8'h80;
  localparam logic [7:0] CMD_CLEAR     = 8'h81;
  localparam logic [7:0] CMD_BACKSPACE = 8'h82;

  state_t     state;
  logic [7:0] clr_addr;
  logic [7:0] cursor;
  logic [6:0] mem [256];

  logic       accept;
  logic       mem_we;
  logic [7:0] mem_waddr;
  logic [6:0] mem_wdata;

  assign accept    = wr_valid && (state == IDLE);
  assign wr_ready  = (state == IDLE);
  assign busy      = (state == CLEAR);
  assign cursor_xy = cursor;

  // Single write port shared by the blanking sweep and accepted commands;
  // the two never coincide because commands are only taken in IDLE.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = cursor;
    mem_wdata = wr_data[6:0];
    if (state == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr;
      mem_wdata = BLANK_CODE;
    end else if (accept) begin
      if (!wr_data[7]) begin
        mem_we = 1'b1;
      end else if (wr_data == CMD_BACKSPACE && cursor != 8'h00) begin
        mem_we    = 1'b1;
        mem_waddr = cursor - 8'd1;
        mem_wdata = BLANK_CODE;
      end
    end
  end

  // Storage is deliberately not reset; the post-reset sweep blanks it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CLEAR;
      clr_addr  <= '0;
      cursor    <= '0;
      char_code <= BLANK_CODE;
    end else begin
      // Non-blocking read sees the pre-edge contents on a same-address write.
      char_code <= (state == CLEAR) ? BLANK_CODE : mem[char_xy];
      case (state)
        CLEAR: begin
          clr_addr <= clr_addr + 8'd1;
          if (clr_addr == 8'hff) begin
            state <= IDLE;
          end
        end
        IDLE: begin
          if (accept) begin
            if (!wr_data[7]) begin
              cursor <= cursor + 8'd1;
            end else if (wr_data == CMD_NEWLINE) begin
              cursor <= {cursor[7:4] + 4'd1, 4'h0};
            end else if (wr_data == CMD_CLEAR) begin
              cursor   <= '0;
              clr_addr <= '0;
              state    <= CLEAR;
            end else if (wr_data == CMD_BACKSPACE) begin
              if (cursor != 8'h00) begin
                cursor <= cursor - 8'd1;
              end
            end
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule
